stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//   Consumer end of the stopwatch tick interface. Counts single-cycle tick pulses
//   from the stopwatch pulse generator into a BCD MM:SS.cc time value.
//   A run/stop/lap state machine, driven by one-cycle button pulses, controls
//   counting and freezes the display on lap. Outputs drive the display mux.
// PARAMETERS
//   TICKS_PER_CS  1   tick pulses per centisecond (prescaler modulus, >=1)
//   MAX_MIN       59  highest minutes value; wraps to 00 after MAX_MIN:59.99 (<=99)
// PORTS
//   clk         in   1  system clock, all logic rising-edge
//   rst         in   1  asynchronous, active-high reset
//   tick        in   1  one-cycle pulse from pulse generator; one tick = 1/TICKS_PER_CS cs
//   start_stop  in   1  one-cycle pulse (debounced button): toggle run/stop
//   lap         in   1  one-cycle pulse: freeze/release displayed value while running
//   clear       in   1  synchronous clear, level-sensitive, valid in any state
//   cs_o, cs_t  out  4  BCD centiseconds ones/tens shown on display
//   s_o, s_t    out  4  BCD seconds ones/tens (s_t 0..5)
//   m_o, m_t    out  4  BCD minutes ones/tens
//   running     out  1  1 in RUN or LAP
//   lap_active  out  1  1 in LAP (display frozen)
//   wrap        out  1  one-cycle pulse when the live count wraps MAX_MIN:59.99 -> 00:00.00
// BEHAVIOUR
//   Reset: state=IDLE; live count, lap latch and prescaler = 0; all outputs 0.
//   States: IDLE (zero, stopped), RUN, LAP (counting, display frozen), STOP (paused).
//   Transitions (evaluated each clk; priority rst > clear > start_stop > lap):
//     clear=1: any -> IDLE; count, latch, prescaler zeroed; wrap=0.
//     IDLE  +start_stop -> RUN;   lap ignored.
//     RUN   +start_stop -> STOP;  +lap -> LAP (latch <= live count this cycle).
//     LAP   +start_stop -> STOP (freeze released); +lap -> RUN (freeze released).
//     STOP  +start_stop -> RUN;   lap ignored.
//   Counting: tick counted only if current (registered) state is RUN or LAP.
//     Tick coincident with start_stop in RUN is counted; in STOP/IDLE it is not.
//     Tick coincident with clear is discarded.
//   Prescaler: 0..TICKS_PER_CS-1; counted tick at TICKS_PER_CS-1 -> 0 and
//     advances the count by one cs. TICKS_PER_CS=1: every counted tick advances.
//   Count cascade: cs 00..99, s 00..59, m 00..MAX_MIN, each digit pure BCD
//     (never A..F); carry ripples within the same cycle.
//   Latency: digit outputs and wrap update 1 clk after the tick cycle.
//   Wrap: MAX_MIN:59.99 + advance -> 00:00.00, wrap=1 for exactly 1 clk, state unchanged.
//   Display: LAP -> latched value; all other states -> live count.
//   Lap latch: captures the live value as registered in the cycle lap is sampled
//     (the tick in that cycle is counted in live, not in latch).
//   All outputs are registered; no combinational input->output path.
// TESTING
//   1 rst pulse mid-count at 00:03.27 -> all outputs 0, state IDLE, next tick ignored.
//   2 TICKS_PER_CS=1: start_stop, 150 ticks -> 00:01.50, running=1; start_stop, 20 ticks -> still 00:01.50, running=0.
//   3 MAX_MIN=1: run 11999 ticks -> 01:59.99; next tick -> 00:00.00, wrap high 1 clk, running stays 1.
//   4 Lap at 00:00.42, 100 more ticks -> display 00:00.42, lap_active=1; lap again -> 00:01.42.
//   5 start_stop+tick same clk in RUN at 00:00.09 -> 00:00.10, STOP; in STOP -> no change.
//   6 TICKS_PER_CS=10: 25 ticks in RUN -> 00:00.02; clear -> 00:00.00, IDLE; 5 ticks after restart -> 00:00.00 (prescaler reset).

Source files
------------

// File: rtl/stopwatch_if.sv
// Stopwatch tick interface: button/tick pulses toward the counter, BCD display and status back.
interface stopwatch_if;
  logic       tick;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] cs_o;
  logic [3:0] cs_t;
  logic [3:0] s_o;
  logic [3:0] s_t;
  logic [3:0] m_o;
  logic [3:0] m_t;
  logic       running;
  logic       lap_active;
  logic       wrap;

  modport master (
    output tick, start_stop, lap, clear,
    input  cs_o, cs_t, s_o, s_t, m_o, m_t, running, lap_active, wrap
  );

  modport slave (
    input  tick, start_stop, lap, clear,
    output cs_o, cs_t, s_o, s_t, m_o, m_t, running, lap_active, wrap
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Counts tick pulses into a BCD MM:SS.cc time under a run/stop/lap state machine;
// the lap state freezes the displayed value while the live count keeps running.
module stopwatch_counter #(
  parameter int unsigned TICKS_PER_CS = 1,
  parameter int unsigned MAX_MIN      = 59
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  localparam int unsigned PW       = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_CS - 1);
  localparam logic [3:0]  MAX_T    = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_O    = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_e;

  typedef struct packed {
    logic [3:0] m_t;
    logic [3:0] m_o;
    logic [3:0] s_t;
    logic [3:0] s_o;
    logic [3:0] cs_t;
    logic [3:0] cs_o;
  } bcd_t;

  state_e        state_q, state_d;
  bcd_t          live_q, live_d;
  bcd_t          latch_q, latch_d;
  bcd_t          disp_q, disp_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          running_q, running_d;
  logic          lap_q, lap_d;
  logic          wrap_q, wrap_d;
  logic          counting;
  logic          advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      live_q    <= '0;
      latch_q   <= '0;
      disp_q    <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      latch_q   <= latch_d;
      disp_q    <= disp_d;
      pre_q     <= pre_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    latch_d  = latch_q;
    pre_d    = pre_q;
    wrap_d   = 1'b0;
    advance  = 1'b0;
    counting = sw.tick && ((state_q == RUN) || (state_q == LAP));

    if (sw.clear) begin
      state_d = IDLE;
      live_d  = '0;
      latch_d = '0;
      pre_d   = '0;
    end else begin
      if (counting) begin
        if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          advance = 1'b1;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      // BCD cascade; every carry resolves in this cycle
      if (advance) begin
        if (live_q.cs_o != 4'd9) live_d.cs_o = live_q.cs_o + 4'd1;
        else begin
          live_d.cs_o = '0;
          if (live_q.cs_t != 4'd9) live_d.cs_t = live_q.cs_t + 4'd1;
          else begin
            live_d.cs_t = '0;
            if (live_q.s_o != 4'd9) live_d.s_o = live_q.s_o + 4'd1;
            else begin
              live_d.s_o = '0;
              if (live_q.s_t != 4'd5) live_d.s_t = live_q.s_t + 4'd1;
              else begin
                live_d.s_t = '0;
                if ((live_q.m_t == MAX_T) && (live_q.m_o == MAX_O)) begin
                  live_d.m_t = '0;
                  live_d.m_o = '0;
                  wrap_d     = 1'b1;
                end else if (live_q.m_o != 4'd9) begin
                  live_d.m_o = live_q.m_o + 4'd1;
                end else begin
                  live_d.m_o = '0;
                  live_d.m_t = live_q.m_t + 4'd1;
                end
              end
            end
          end
        end
      end

      // start_stop outranks lap; the latch takes the pre-tick live value
      unique case (state_q)
        IDLE: if (sw.start_stop) state_d = RUN;
        RUN: begin
          if (sw.start_stop) state_d = STOP;
          else if (sw.lap) begin
            state_d = LAP;
            latch_d = live_q;
          end
        end
        LAP: begin
          if (sw.start_stop) state_d = STOP;
          else if (sw.lap)   state_d = RUN;
        end
        STOP: if (sw.start_stop) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN) || (state_d == LAP);
    lap_d     = (state_d == LAP);
    disp_d    = lap_d ? latch_d : live_d;
  end

  assign sw.cs_o       = disp_q.cs_o;
  assign sw.cs_t       = disp_q.cs_t;
  assign sw.s_o        = disp_q.s_o;
  assign sw.s_t        = disp_q.s_t;
  assign sw.m_o        = disp_q.m_o;
  assign sw.m_t        = disp_q.m_t;
  assign sw.running    = running_q;
  assign sw.lap_active = lap_q;
  assign sw.wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: three parameterisations share one stimulus stream,
// checked every cycle against a behavioural model plus fixed expectations from a vector table.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst;
  logic tick, ss, lap_r, clr;

  always #5 clk = ~clk;

  stopwatch_if if_a ();
  stopwatch_if if_b ();
  stopwatch_if if_c ();

  assign if_a.tick = tick;  assign if_a.start_stop = ss;  assign if_a.lap = lap_r;  assign if_a.clear = clr;
  assign if_b.tick = tick;  assign if_b.start_stop = ss;  assign if_b.lap = lap_r;  assign if_b.clear = clr;
  assign if_c.tick = tick;  assign if_c.start_stop = ss;  assign if_c.lap = lap_r;  assign if_c.clear = clr;

  stopwatch_counter #(.TICKS_PER_CS(1),  .MAX_MIN(59)) u_a (.clk(clk), .rst(rst), .sw(if_a));
  stopwatch_counter #(.TICKS_PER_CS(1),  .MAX_MIN(1))  u_b (.clk(clk), .rst(rst), .sw(if_b));
  stopwatch_counter #(.TICKS_PER_CS(10), .MAX_MIN(59)) u_c (.clk(clk), .rst(rst), .sw(if_c));

  typedef struct packed {
    logic [23:0] disp;
    logic        running;
    logic        lap_active;
    logic        wrap;
  } out_t;

  typedef struct {
    bit          t, s, l, c;
    int          n;
    int          inst;
    logic [23:0] disp;
    bit          run, lp, wr;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  out_t sb_q[$];
  vec_t vecs[$];

  // model: state 0 IDLE, 1 RUN, 2 LAP, 3 STOP; times held as integer centiseconds
  int   tpc  [3] = '{1, 1, 10};
  int   maxm [3] = '{59, 1, 59};
  int   ms   [3];
  int   live [3];
  int   latch[3];
  int   pre  [3];
  out_t mout [3];

  function automatic logic [23:0] to_bcd(input int v);
    int cs  = v % 100;
    int sec = (v / 100) % 60;
    int mn  = v / 6000;
    return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic out_t dut_out(input int i);
    out_t o;
    case (i)
      0:       o = '{{if_a.m_t, if_a.m_o, if_a.s_t, if_a.s_o, if_a.cs_t, if_a.cs_o}, if_a.running, if_a.lap_active, if_a.wrap};
      1:       o = '{{if_b.m_t, if_b.m_o, if_b.s_t, if_b.s_o, if_b.cs_t, if_b.cs_o}, if_b.running, if_b.lap_active, if_b.wrap};
      default: o = '{{if_c.m_t, if_c.m_o, if_c.s_t, if_c.s_o, if_c.cs_t, if_c.cs_o}, if_c.running, if_c.lap_active, if_c.wrap};
    endcase
    return o;
  endfunction

  function automatic vec_t mk(bit t, bit s, bit l, bit c, int n, int inst,
                              logic [23:0] disp, bit run, bit lp, bit wr);
    vec_t v;
    v.t = t; v.s = s; v.l = l; v.c = c; v.n = n; v.inst = inst;
    v.disp = disp; v.run = run; v.lp = lp; v.wr = wr;
    return v;
  endfunction

  task automatic cmp(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got disp=%h run=%b lap=%b wrap=%b expected disp=%h run=%b lap=%b wrap=%b",
               name, cyc, got.disp, got.running, got.lap_active, got.wrap,
               exp.disp, exp.running, exp.lap_active, exp.wrap);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ms[i] = 0; live[i] = 0; latch[i] = 0; pre[i] = 0; mout[i] = '0;
    end
  endtask

  task automatic model_step(input bit t, input bit s, input bit l, input bit c);
    for (int i = 0; i < 3; i++) begin
      int old = live[i];
      bit wr  = 1'b0;
      if (c) begin
        ms[i] = 0; live[i] = 0; latch[i] = 0; pre[i] = 0;
      end else begin
        if (t && (ms[i] == 1 || ms[i] == 2)) begin
          if (pre[i] == tpc[i] - 1) begin
            pre[i] = 0;
            live[i]++;
            if (live[i] == (maxm[i] + 1) * 6000) begin
              live[i] = 0;
              wr      = 1'b1;
            end
          end else pre[i]++;
        end
        case (ms[i])
          0: if (s) ms[i] = 1;
          1: if (s) ms[i] = 3; else if (l) begin ms[i] = 2; latch[i] = old; end
          2: if (s) ms[i] = 3; else if (l) ms[i] = 1;
          default: if (s) ms[i] = 1;
        endcase
      end
      mout[i].running    = (ms[i] == 1) || (ms[i] == 2);
      mout[i].lap_active = (ms[i] == 2);
      mout[i].disp       = to_bcd((ms[i] == 2) ? latch[i] : live[i]);
      mout[i].wrap       = wr;
      sb_q.push_back(mout[i]);
    end
  endtask

  // drive one cycle of inputs, then pop and compare each instance against the scoreboard
  task automatic step(input bit t, input bit s, input bit l, input bit c);
    out_t e;
    @(negedge clk);
    tick = t; ss = s; lap_r = l; clr = c;
    model_step(t, s, l, c);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front();
      cmp($sformatf("sb_inst%0d", i), dut_out(i), e);
    end
  endtask

  initial begin
    out_t want;
    rst = 1'b1; tick = 1'b0; ss = 1'b0; lap_r = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cmp($sformatf("reset_inst%0d", i), dut_out(i), out_t'(0));
    @(negedge clk);
    rst = 1'b0;

    // start/stop with counting, stopped ticks ignored, lap/tick ignored when idle
    vecs.push_back(mk(0,1,0,0,   1,-1, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,0,0, 150, 0, 24'h000150,1,0,0));
    vecs.push_back(mk(0,1,0,0,   1,-1, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,0,0,  20, 0, 24'h000150,0,0,0));
    vecs.push_back(mk(0,0,1,0,   1, 0, 24'h000150,0,0,0));
    vecs.push_back(mk(1,0,0,1,   1, 0, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,1,0,   1, 0, 24'h000000,0,0,0));
    // start_stop coincident with tick in RUN and in STOP
    vecs.push_back(mk(0,1,0,0,   1, 0, 24'h000000,1,0,0));
    vecs.push_back(mk(1,0,0,0,   9, 0, 24'h000009,1,0,0));
    vecs.push_back(mk(1,1,0,0,   1, 0, 24'h000010,0,0,0));
    vecs.push_back(mk(1,1,0,0,   1, 0, 24'h000010,1,0,0));
    vecs.push_back(mk(1,0,0,0,   1, 0, 24'h000011,1,0,0));
    // lap freeze and release, lap with coincident tick
    vecs.push_back(mk(0,0,0,1,   1, 0, 24'h000000,0,0,0));
    vecs.push_back(mk(0,1,0,0,   1,-1, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,0,0,  42, 0, 24'h000042,1,0,0));
    vecs.push_back(mk(0,0,1,0,   1, 0, 24'h000042,1,1,0));
    vecs.push_back(mk(1,0,0,0, 100, 0, 24'h000042,1,1,0));
    vecs.push_back(mk(0,0,1,0,   1, 0, 24'h000142,1,0,0));
    vecs.push_back(mk(0,0,1,0,   1, 0, 24'h000142,1,1,0));
    vecs.push_back(mk(1,0,1,0,   1, 0, 24'h000143,1,0,0));
    vecs.push_back(mk(1,0,1,0,   1, 0, 24'h000143,1,1,0));
    vecs.push_back(mk(0,1,0,0,   1, 0, 24'h000144,0,0,0));
    // prescaler of 10, cleared along with the count
    vecs.push_back(mk(0,0,0,1,   1, 2, 24'h000000,0,0,0));
    vecs.push_back(mk(0,1,0,0,   1,-1, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,0,0,  25, 2, 24'h000002,1,0,0));
    vecs.push_back(mk(1,0,0,1,   1, 2, 24'h000000,0,0,0));
    vecs.push_back(mk(0,1,0,0,   1,-1, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,0,0,   5, 2, 24'h000000,1,0,0));
    vecs.push_back(mk(1,0,0,0,   5, 2, 24'h000001,1,0,0));
    // wrap at MAX_MIN=1
    vecs.push_back(mk(0,0,0,1,   1, 1, 24'h000000,0,0,0));
    vecs.push_back(mk(0,1,0,0,   1,-1, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,0,0,11999,1, 24'h015999,1,0,0));
    vecs.push_back(mk(1,0,0,0,   1, 1, 24'h000000,1,0,1));
    vecs.push_back(mk(0,0,0,0,   1, 1, 24'h000000,1,0,0));
    // count up to 00:03.27 ahead of the mid-count reset
    vecs.push_back(mk(0,0,0,1,   1, 0, 24'h000000,0,0,0));
    vecs.push_back(mk(0,1,0,0,   1,-1, 24'h000000,0,0,0));
    vecs.push_back(mk(1,0,0,0, 327, 0, 24'h000327,1,0,0));

    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].n; r++) step(vecs[k].t, vecs[k].s, vecs[k].l, vecs[k].c);
      if (vecs[k].inst >= 0) begin
        want = '{vecs[k].disp, vecs[k].run, vecs[k].lp, vecs[k].wr};
        cmp($sformatf("vec%0d_inst%0d", k, vecs[k].inst), dut_out(vecs[k].inst), want);
      end
    end

    // asynchronous reset mid-count while a tick is pending
    @(negedge clk);
    tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) cmp($sformatf("rst_async_inst%0d", i), dut_out(i), out_t'(0));
    model_reset();
    @(posedge clk);
    #1;
    cmp("rst_hold", dut_out(0), out_t'(0));
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    step(1, 0, 0, 0);
    cmp("tick_after_rst", dut_out(0), out_t'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
